// File: rtl/register_mode_decoder.sv
// Receive side of the mode-select register: undoes pass/invert/shift transforms,
// flags lost bits and zero-fill violations, and queues results in a small FIFO.
module register_mode_decoder #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] Y_IN,
  input  logic [1:0]       S_IN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] D_OUT,
  output logic [WIDTH-1:0] KNOWN_OUT,
  output logic             ERR_OUT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [CNT_W-1:0] LOSSY_CNT,
  output logic [CNT_W-1:0] ERR_CNT
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int ENT_W = 2 * WIDTH + 1;

  logic [WIDTH-1:0] dec_data_s;
  logic [WIDTH-1:0] dec_known_s;
  logic             dec_err_s;
  logic [ENT_W-1:0] entry_s;
  logic [ENT_W-1:0] head_s;
  logic             push_s;
  logic             pop_s;

  logic [ENT_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [OCC_W-1:0] occ_r;
  logic [CNT_W-1:0] lossy_cnt_r;
  logic [CNT_W-1:0] err_cnt_r;

  // Inverse transform of the incoming word; shift modes lose one edge bit each.
  always_comb begin
    dec_data_s  = '0;
    dec_known_s = '1;
    dec_err_s   = 1'b0;
    case (S_IN)
      2'b00: dec_data_s = Y_IN;
      2'b01: dec_data_s = ~Y_IN;
      2'b10: begin
        dec_data_s  = {Y_IN[WIDTH-2:0], 1'b0};
        dec_known_s = {{(WIDTH-1){1'b1}}, 1'b0};
        dec_err_s   = Y_IN[WIDTH-1];
      end
      2'b11: begin
        dec_data_s  = {1'b0, Y_IN[WIDTH-1:1]};
        dec_known_s = {1'b0, {(WIDTH-1){1'b1}}};
        dec_err_s   = Y_IN[0];
      end
      default: begin
        dec_data_s  = '0;
        dec_known_s = '0;
        dec_err_s   = 1'b0;
      end
    endcase
  end

  assign entry_s   = {dec_err_s, dec_known_s, dec_data_s};
  assign IN_READY  = (occ_r != OCC_W'(DEPTH));
  assign OUT_VALID = (occ_r != OCC_W'(0));
  assign push_s    = IN_VALID & IN_READY;
  assign pop_s     = OUT_VALID & OUT_READY;
  assign head_s    = mem_r[rd_ptr_r];

  // Empty FIFO presents all-zero fields so stale storage never leaks out.
  assign D_OUT     = OUT_VALID ? head_s[WIDTH-1:0]       : '0;
  assign KNOWN_OUT = OUT_VALID ? head_s[2*WIDTH-1:WIDTH] : '0;
  assign ERR_OUT   = OUT_VALID ? head_s[ENT_W-1]         : 1'b0;
  assign LOSSY_CNT = lossy_cnt_r;
  assign ERR_CNT   = err_cnt_r;

  // Entry storage, written only on accept.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= entry_s;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Saturating statistics, counted at accept time.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lossy_cnt_r <= '0;
      err_cnt_r   <= '0;
    end else begin
      if (push_s && S_IN[1] && (lossy_cnt_r != '1)) begin
        lossy_cnt_r <= lossy_cnt_r + CNT_W'(1);
      end
      if (push_s && dec_err_s && (err_cnt_r != '1)) begin
        err_cnt_r <= err_cnt_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_register_mode_decoder.sv
// Directed self-checking bench for register_mode_decoder (WIDTH=4, DEPTH=2, CNT_W=8).
module tb_register_mode_decoder;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] Y_IN;
  logic [1:0] S_IN;
  logic       IN_VALID;
  logic       IN_READY;
  logic [3:0] D_OUT;
  logic [3:0] KNOWN_OUT;
  logic       ERR_OUT;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [7:0] LOSSY_CNT;
  logic [7:0] ERR_CNT;

  int errors = 0;
  int checks = 0;

  register_mode_decoder #(.WIDTH(4), .DEPTH(2), .CNT_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .Y_IN(Y_IN), .S_IN(S_IN), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .D_OUT(D_OUT), .KNOWN_OUT(KNOWN_OUT), .ERR_OUT(ERR_OUT),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .LOSSY_CNT(LOSSY_CNT), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic head(input string tag, input logic [3:0] d, input logic [3:0] k, input logic e);
    check({tag, ".valid"}, 32'(OUT_VALID), 32'd1);
    check({tag, ".d"}, 32'(D_OUT), 32'(d));
    check({tag, ".known"}, 32'(KNOWN_OUT), 32'(k));
    check({tag, ".err"}, 32'(ERR_OUT), 32'(e));
  endtask

  task automatic empty(input string tag);
    check({tag, ".valid"}, 32'(OUT_VALID), 32'd0);
    check({tag, ".d"}, 32'(D_OUT), 32'd0);
    check({tag, ".known"}, 32'(KNOWN_OUT), 32'd0);
    check({tag, ".err"}, 32'(ERR_OUT), 32'd0);
  endtask

  initial begin
    RESET = 1'b1; Y_IN = 4'b0000; S_IN = 2'b00; IN_VALID = 1'b0; OUT_READY = 1'b0;
    #2;
    empty("rst");
    check("rst.in_ready", 32'(IN_READY), 32'd1);
    check("rst.lossy", 32'(LOSSY_CNT), 32'd0);
    check("rst.errcnt", 32'(ERR_CNT), 32'd0);
    #10 RESET = 1'b0;

    // Pass then invert, streaming with OUT_READY high
    OUT_READY = 1'b1; IN_VALID = 1'b1; Y_IN = 4'b1010; S_IN = 2'b00;
    step();
    head("pass", 4'b1010, 4'b1111, 1'b0);
    check("pass.lossy", 32'(LOSSY_CNT), 32'd0);
    S_IN = 2'b01;
    step();
    head("inv", 4'b0101, 4'b1111, 1'b0);
    check("inv.lossy", 32'(LOSSY_CNT), 32'd0);
    IN_VALID = 1'b0;
    step();
    empty("drain1");

    // Shift modes, clean zero fill
    IN_VALID = 1'b1; Y_IN = 4'b0101; S_IN = 2'b10;
    step();
    head("shr", 4'b1010, 4'b1110, 1'b0);
    Y_IN = 4'b1010; S_IN = 2'b11;
    step();
    head("shl", 4'b0101, 4'b0111, 1'b0);
    IN_VALID = 1'b0;
    step();
    check("shift.lossy", 32'(LOSSY_CNT), 32'd2);
    check("shift.errcnt", 32'(ERR_CNT), 32'd0);

    // Zero-fill violations
    IN_VALID = 1'b1; Y_IN = 4'b1001; S_IN = 2'b10;
    step();
    head("zf10", 4'b0010, 4'b1110, 1'b1);
    Y_IN = 4'b0011; S_IN = 2'b11;
    step();
    head("zf11", 4'b0001, 4'b0111, 1'b1);
    IN_VALID = 1'b0;
    step();
    check("zf.errcnt", 32'(ERR_CNT), 32'd2);
    check("zf.lossy", 32'(LOSSY_CNT), 32'd4);

    // Backpressure: A, B fill the FIFO, C is held off
    OUT_READY = 1'b0; IN_VALID = 1'b1; Y_IN = 4'b0001; S_IN = 2'b00;
    step();
    check("bp.a.in_ready", 32'(IN_READY), 32'd1);
    Y_IN = 4'b0010;
    step();
    check("bp.full.in_ready", 32'(IN_READY), 32'd0);
    head("bp.full", 4'b0001, 4'b1111, 1'b0);
    Y_IN = 4'b0011;
    step();
    check("bp.held.in_ready", 32'(IN_READY), 32'd0);
    head("bp.held", 4'b0001, 4'b1111, 1'b0);
    OUT_READY = 1'b1;
    step();
    head("bp.popA", 4'b0010, 4'b1111, 1'b0);
    check("bp.popA.in_ready", 32'(IN_READY), 32'd1);
    step();
    head("bp.pushpop", 4'b0011, 4'b1111, 1'b0);
    check("bp.pushpop.in_ready", 32'(IN_READY), 32'd1);
    IN_VALID = 1'b0;
    step();
    empty("bp.drain");
    check("bp.lossy", 32'(LOSSY_CNT), 32'd4);

    // Saturation of LOSSY_CNT (starts at 4)
    IN_VALID = 1'b1; Y_IN = 4'b0000; S_IN = 2'b10;
    for (int i = 0; i < 250; i++) step();
    check("sat.254", 32'(LOSSY_CNT), 32'd254);
    for (int i = 0; i < 50; i++) step();
    check("sat.255", 32'(LOSSY_CNT), 32'd255);
    check("sat.errcnt", 32'(ERR_CNT), 32'd2);
    IN_VALID = 1'b0;
    step();

    // Reset between edges, then build FIFO full with LOSSY_CNT=5
    RESET = 1'b1;
    #2;
    check("rst2.lossy", 32'(LOSSY_CNT), 32'd0);
    RESET = 1'b0;
    IN_VALID = 1'b1; Y_IN = 4'b0001; S_IN = 2'b10; OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) step();
    OUT_READY = 1'b0;
    step();
    check("pre.lossy", 32'(LOSSY_CNT), 32'd5);
    check("pre.in_ready", 32'(IN_READY), 32'd0);
    head("pre", 4'b0010, 4'b1110, 1'b0);
    IN_VALID = 1'b0;
    #2 RESET = 1'b1;
    #1;
    empty("async");
    check("async.lossy", 32'(LOSSY_CNT), 32'd0);
    check("async.errcnt", 32'(ERR_CNT), 32'd0);
    check("async.in_ready", 32'(IN_READY), 32'd1);
    step();
    check("rsthold.in_ready", 32'(IN_READY), 32'd1);
    empty("rsthold");
    RESET = 1'b0;
    IN_VALID = 1'b1; Y_IN = 4'b0110; S_IN = 2'b00;
    step();
    head("post", 4'b0110, 4'b1111, 1'b0);
    check("post.in_ready", 32'(IN_READY), 32'd1);
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    step();
    empty("post.alone");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
